regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with three combinational read ports,
// two write ports, optional same-cycle write-to-read forwarding, an optional
// hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] raddr_c,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] DOut1,
    output logic [DATA_W-1:0] DOut2,
    output logic [DATA_W-1:0] DOut3,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_bits;

    logic              wr_en0;
    logic              wr_en1;
    logic              rsv_en;
    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];
    logic              rd_busy [3];
    logic              unused_instr;

    // Qualified write/reserve enables: with a zero register, address 0 is never
    // written, forwarded or reserved, so register 0 and its busy bit stay 0.
    always_comb begin
        wr_en0 = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
        wr_en1 = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
        rsv_en = rsv && !((ZERO_REG != 0) && (rsv_addr == '0));
    end

    // Read address decode: ports A/B come from the instruction's rs/rt fields.
    always_comb begin
        rd_addr[0]   = ADDR_W'(instruction[25:21]);
        rd_addr[1]   = ADDR_W'(instruction[20:16]);
        rd_addr[2]   = raddr_c;
        unused_instr = ^{instruction[31:26], instruction[15:0]};
    end

    // Register and scoreboard update; port 1 is applied after port 0 so it wins
    // a same-address collision, and a reserve is applied last so a new producer
    // keeps the busy bit set even when a write to that register lands together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_bits <= '0;
        end else begin
            if (wr_en0) begin
                regs[waddr0]      <= wdata0;
                busy_bits[waddr0] <= 1'b0;
            end
            if (wr_en1) begin
                regs[waddr1]      <= wdata1;
                busy_bits[waddr1] <= 1'b0;
            end
            if (rsv_en) begin
                busy_bits[rsv_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional forwarding (port 1 has priority);
    // busy is never forwarded, and everything reads as 0 while in reset.
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy_bits[rd_addr[p]];
            if ((BYPASS != 0) && wr_en0 && (waddr0 == rd_addr[p])) begin
                rd_data[p] = wdata0;
            end
            if ((BYPASS != 0) && wr_en1 && (waddr1 == rd_addr[p])) begin
                rd_data[p] = wdata1;
            end
            if (!rst_n) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    // Output mapping.
    always_comb begin
        DOut1 = rd_data[0];
        DOut2 = rd_data[1];
        DOut3 = rd_data[2];
        busy1 = rd_busy[0];
        busy2 = rd_busy[1];
        busy3 = rd_busy[2];
    end

endmodule
